// File: rtl/seu_shift_chain_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : seu_shift_chain_ctrl
// Brief    : Fill/hold/readout sequencer for an SEU test shift chain with
//            per-run and cumulative upset counting.
//            Optional first-error index capture: SEU_SHIFT_CHAIN_CTRL_ERRLOG_EN
// Revision : 1.0 - initial release
//==============================================================================
module seu_shift_chain_ctrl #(
    parameter int LENGTH = 50,
    parameter int HOLD_W = 16,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    input  logic [1:0]        pattern_sel,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              sr_mode,
    output logic              sr_din,
    input  logic              sr_dout,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  run_errs,
    output logic [CNT_W-1:0]  total_errs,
    output logic [CNT_W-1:0]  run_count,
    output logic [IDX_W-1:0]  first_err_idx
);

    localparam logic [1:0]       c_idle     = 2'd0;
    localparam logic [1:0]       c_fill     = 2'd1;
    localparam logic [1:0]       c_hold     = 2'd2;
    localparam logic [1:0]       c_readout  = 2'd3;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(LENGTH - 1);
    localparam logic [IDX_W-1:0] c_zero_idx = '0;

    // Index is zero-extended so bit 1 exists even for a 2-bit chain.
    function automatic logic f_pattern(input logic [1:0] sel, input logic [IDX_W-1:0] idx);
        logic [IDX_W:0] w_ext;
        w_ext = {1'b0, idx};
        case (sel)
            2'b00:   f_pattern = 1'b0;
            2'b01:   f_pattern = 1'b1;
            2'b10:   f_pattern = w_ext[0];
            default: f_pattern = w_ext[1];
        endcase
    endfunction

    logic [1:0]        r_state;
    logic              r_cont;
    logic [1:0]        r_pat;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_acc;
    logic              r_sr_mode;
    logic              r_sr_din;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_run_errs;
    logic [CNT_W-1:0]  r_total_errs;
    logic [CNT_W-1:0]  r_run_count;

    logic              w_mismatch;
    logic              w_readout_entry;
    logic              w_readout_last;
    logic [IDX_W-1:0]  w_idx_next;
    logic [HOLD_W-1:0] w_hold_load;
    logic [CNT_W-1:0]  w_acc_final;
    logic [CNT_W:0]    w_total_sum;
    logic [CNT_W-1:0]  w_total_final;

    assign w_mismatch      = (r_state == c_readout) && (sr_dout != f_pattern(r_pat, r_idx));
    assign w_readout_entry = (r_state == c_hold) && (r_hold_cnt == '0);
    assign w_readout_last  = (r_state == c_readout) && (r_idx == c_last_idx);
    assign w_idx_next      = r_idx + IDX_W'(1);
    // A zero exposure request still spends one cycle in HOLD.
    assign w_hold_load     = (r_hold == '0) ? '0 : r_hold - HOLD_W'(1);
    assign w_acc_final     = (w_mismatch && (r_acc != '1)) ? r_acc + CNT_W'(1) : r_acc;
    assign w_total_sum     = {1'b0, r_total_errs} + {1'b0, w_acc_final};
    assign w_total_final   = w_total_sum[CNT_W] ? '1 : w_total_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_idle;
            r_cont       <= 1'b0;
            r_pat        <= 2'b00;
            r_hold       <= '0;
            r_hold_cnt   <= '0;
            r_idx        <= '0;
            r_acc        <= '0;
            r_sr_mode    <= 1'b0;
            r_sr_din     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_run_errs   <= '0;
            r_total_errs <= '0;
            r_run_count  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_state      <= c_fill;
                        r_cont       <= continuous;
                        r_pat        <= pattern_sel;
                        r_hold       <= hold_cycles;
                        r_run_errs   <= '0;
                        r_total_errs <= '0;
                        r_run_count  <= '0;
                        r_idx        <= '0;
                        r_sr_mode    <= 1'b1;
                        r_sr_din     <= f_pattern(pattern_sel, c_zero_idx);
                        r_busy       <= 1'b1;
                    end
                end
                c_fill: begin
                    if (r_idx == c_last_idx) begin
                        r_state    <= c_hold;
                        r_sr_mode  <= 1'b0;
                        r_sr_din   <= 1'b0;
                        r_hold_cnt <= w_hold_load;
                    end else begin
                        r_idx    <= w_idx_next;
                        r_sr_din <= f_pattern(r_pat, w_idx_next);
                    end
                end
                c_hold: begin
                    if (w_readout_entry) begin
                        r_state   <= c_readout;
                        r_idx     <= '0;
                        r_acc     <= '0;
                        r_sr_mode <= 1'b1;
                        r_sr_din  <= f_pattern(r_pat, c_zero_idx);
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                c_readout: begin
                    if (w_readout_last) begin
                        r_done       <= 1'b1;
                        r_run_errs   <= w_acc_final;
                        r_total_errs <= w_total_final;
                        r_run_count  <= r_run_count + CNT_W'(1);
                        r_sr_mode    <= 1'b0;
                        r_sr_din     <= 1'b0;
                        // The readout has already refilled the chain, so loop straight to HOLD.
                        if (r_cont && !stop) begin
                            r_state    <= c_hold;
                            r_hold_cnt <= w_hold_load;
                        end else begin
                            r_state <= c_idle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_acc    <= w_acc_final;
                        r_idx    <= w_idx_next;
                        r_sr_din <= f_pattern(r_pat, w_idx_next);
                    end
                end
                default: begin
                    r_state   <= c_idle;
                    r_sr_mode <= 1'b0;
                    r_sr_din  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEU_SHIFT_CHAIN_CTRL_ERRLOG_EN
    logic             r_err_found;
    logic [IDX_W-1:0] r_err_idx;
    logic [IDX_W-1:0] r_first_err_idx;
    logic [IDX_W-1:0] w_first_final;

    // The final bit's mismatch is folded in combinationally on the done edge.
    assign w_first_final = r_err_found ? r_err_idx : (w_mismatch ? r_idx : '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_found     <= 1'b0;
            r_err_idx       <= '1;
            r_first_err_idx <= '1;
        end else begin
            if (w_readout_entry) begin
                r_err_found <= 1'b0;
                r_err_idx   <= '1;
            end else if (w_mismatch && !r_err_found) begin
                r_err_found <= 1'b1;
                r_err_idx   <= r_idx;
            end
            if (w_readout_last) begin
                r_first_err_idx <= w_first_final;
            end
        end
    end

    assign first_err_idx = r_first_err_idx;
`else
    assign first_err_idx = '1;
`endif

    assign sr_mode    = r_sr_mode;
    assign sr_din     = r_sr_din;
    assign busy       = r_busy;
    assign done       = r_done;
    assign run_errs   = r_run_errs;
    assign total_errs = r_total_errs;
    assign run_count  = r_run_count;

endmodule
`default_nettype wire

// File: tb/tb_seu_shift_chain_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_seu_shift_chain_ctrl
// Brief    : Directed bench for seu_shift_chain_ctrl with an 8-bit chain model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_seu_shift_chain_ctrl;

`ifdef SEU_SHIFT_CHAIN_CTRL_ERRLOG_EN
    localparam bit ERRLOG = 1'b1;
`else
    localparam bit ERRLOG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic        continuous = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  pattern_sel = 2'b00;
    logic [15:0] hold_cycles = 16'd0;
    logic [7:0]  flip_mask = 8'h00;
    logic        stuck_en = 1'b0;
    logic [7:0]  chain = 8'h00;
    logic [7:0]  chain_s = 8'h00;

    logic        sr_mode, sr_din, sr_dout, busy, done;
    logic [15:0] run_errs, total_errs, run_count;
    logic [2:0]  first_err_idx;

    logic        sr_mode_s, sr_din_s, sr_dout_s, busy_s, done_s;
    logic [2:0]  run_errs_s, total_errs_s, run_count_s, first_err_idx_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Chain model: position 0 at the input, position 7 drives sr_dout.
    always @(posedge clk) begin
        if (sr_mode) chain <= {chain[6:0], sr_din};
        else         chain <= chain ^ flip_mask;
        if (sr_mode_s) chain_s <= {chain_s[6:0], sr_din_s};
    end
    assign sr_dout   = stuck_en ? 1'b0 : chain[7];
    assign sr_dout_s = stuck_en ? 1'b0 : chain_s[7];

    seu_shift_chain_ctrl #(.LENGTH(8), .HOLD_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
        .pattern_sel(pattern_sel), .hold_cycles(hold_cycles),
        .sr_mode(sr_mode), .sr_din(sr_din), .sr_dout(sr_dout),
        .busy(busy), .done(done), .run_errs(run_errs), .total_errs(total_errs),
        .run_count(run_count), .first_err_idx(first_err_idx)
    );

    seu_shift_chain_ctrl #(.LENGTH(8), .HOLD_W(16), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .continuous(continuous), .stop(stop),
        .pattern_sel(pattern_sel), .hold_cycles(hold_cycles),
        .sr_mode(sr_mode_s), .sr_din(sr_din_s), .sr_dout(sr_dout_s),
        .busy(busy_s), .done(done_s), .run_errs(run_errs_s), .total_errs(total_errs_s),
        .run_count(run_count_s), .first_err_idx(first_err_idx_s)
    );

    // Leaves the bench at the negedge following the edge that samples start (cycle 0).
    task automatic pulse_start(input logic [1:0] pat, input logic [15:0] hold, input logic cont);
        @(negedge clk);
        pattern_sel = pat; hold_cycles = hold; continuous = cont; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_one(input logic [1:0] pat, input logic [15:0] hold, input int flip_k,
                           input int restart_k, output int dk,
                           output logic [31:0] modes, output logic [31:0] dins);
        dk = -1; modes = '0; dins = '0;
        pulse_start(pat, hold, 1'b0);
        for (int k = 0; k < 100; k++) begin
            if (k < 32) begin
                modes[k] = sr_mode;
                dins[k]  = sr_din;
            end
            if (done === 1'b1) begin
                dk = k;
                break;
            end
            flip_mask = (k == flip_k) ? 8'h08 : 8'h00;
            start     = (k == restart_k);
            if (k == restart_k) begin
                pattern_sel = 2'b00; hold_cycles = 16'd10; continuous = 1'b1;
            end
            @(negedge clk);
        end
        flip_mask = 8'h00;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({sr_mode, sr_din, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {sr_mode, sr_din, busy, done});
        end
        checks++;
        if ({run_errs, total_errs, run_count} !== 48'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", run_errs, total_errs, run_count);
        end
        checks++;
        if (first_err_idx !== 3'd7) begin
            errors++; $display("FAIL reset_fei: got %0d want 7", first_err_idx);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int dk; logic [31:0] modes, dins;
        run_one(2'b01, 16'd4, -1, -1, dk, modes, dins);
        checks++;
        if (dk !== 20) begin errors++; $display("FAIL basic_latency: got %0d want 20", dk); end
        checks++;
        if (modes[19:0] !== 20'hFF0FF) begin
            errors++; $display("FAIL basic_mode: got %h want ff0ff", modes[19:0]);
        end
        checks++;
        if (dins[19:0] !== 20'hFF0FF) begin
            errors++; $display("FAIL basic_din: got %h want ff0ff", dins[19:0]);
        end
        checks++;
        if (run_errs !== 16'd0 || run_count !== 16'd1 || total_errs !== 16'd0) begin
            errors++; $display("FAIL basic_cnt: got %0d/%0d/%0d want 0/0/1", run_errs, total_errs, run_count);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL basic_after: busy %b done %b want 0 0", busy, done);
        end
    endtask

    task automatic test_patterns();
        int dk; logic [31:0] modes, dins;
        run_one(2'b10, 16'd4, -1, -1, dk, modes, dins);
        checks++;
        if (dins[7:0] !== 8'hAA || dins[19:12] !== 8'hAA || run_errs !== 16'd0) begin
            errors++; $display("FAIL pat10: din %h/%h errs %0d want aa/aa 0", dins[7:0], dins[19:12], run_errs);
        end
        run_one(2'b11, 16'd0, -1, -1, dk, modes, dins);
        checks++;
        if (dk !== 17) begin errors++; $display("FAIL hold0_latency: got %0d want 17", dk); end
        checks++;
        if (dins[7:0] !== 8'hCC || dins[16:9] !== 8'hCC || run_errs !== 16'd0) begin
            errors++; $display("FAIL pat11: din %h/%h errs %0d want cc/cc 0", dins[7:0], dins[16:9], run_errs);
        end
        run_one(2'b00, 16'd2, -1, -1, dk, modes, dins);
        checks++;
        if (dins[7:0] !== 8'h00 || run_errs !== 16'd0 || dk !== 18) begin
            errors++; $display("FAIL pat00: din %h errs %0d done %0d want 00 0 18", dins[7:0], run_errs, dk);
        end
    endtask

    task automatic test_upset();
        int dk; logic [31:0] modes, dins;
        run_one(2'b01, 16'd4, 9, -1, dk, modes, dins);
        checks++;
        if (run_errs !== 16'd1 || total_errs !== 16'd1) begin
            errors++; $display("FAIL upset_cnt: got %0d/%0d want 1/1", run_errs, total_errs);
        end
        checks++;
        if (first_err_idx !== (ERRLOG ? 3'd4 : 3'd7)) begin
            errors++; $display("FAIL upset_fei: got %0d want %0d", first_err_idx, ERRLOG ? 4 : 7);
        end
    endtask

    task automatic test_stuck();
        int dk; logic [31:0] modes, dins;
        stuck_en = 1'b1;
        run_one(2'b10, 16'd4, -1, -1, dk, modes, dins);
        checks++;
        if (run_errs !== 16'd4 || total_errs !== 16'd4) begin
            errors++; $display("FAIL stuck_pat10: got %0d/%0d want 4/4", run_errs, total_errs);
        end
        checks++;
        if (first_err_idx !== (ERRLOG ? 3'd1 : 3'd7)) begin
            errors++; $display("FAIL stuck_pat10_fei: got %0d want %0d", first_err_idx, ERRLOG ? 1 : 7);
        end
        run_one(2'b01, 16'd4, -1, -1, dk, modes, dins);
        checks++;
        if (run_errs !== 16'd8 || total_errs !== 16'd8) begin
            errors++; $display("FAIL stuck_pat01: got %0d/%0d want 8/8", run_errs, total_errs);
        end
        checks++;
        if (first_err_idx !== (ERRLOG ? 3'd0 : 3'd7)) begin
            errors++; $display("FAIL stuck_pat01_fei: got %0d want %0d", first_err_idx, ERRLOG ? 0 : 7);
        end
        stuck_en = 1'b0;
    endtask

    task automatic test_continuous();
        int d[4]; int n;
        n = 0;
        pulse_start(2'b01, 16'd0, 1'b1);
        for (int k = 0; k < 60; k++) begin
            if (done === 1'b1) begin
                if (n < 4) d[n] = k;
                n++;
            end
            if (n == 2 && k == d[1] + 3) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        checks++;
        if (n !== 3) begin errors++; $display("FAIL cont_pulses: got %0d want 3", n); end
        else begin
            checks++;
            if (d[0] !== 17 || d[1] !== 26 || d[2] !== 35) begin
                errors++; $display("FAIL cont_spacing: got %0d %0d %0d want 17 26 35", d[0], d[1], d[2]);
            end
        end
        checks++;
        if (run_count !== 16'd3 || busy !== 1'b0 || run_errs !== 16'd0) begin
            errors++; $display("FAIL cont_end: count %0d busy %b errs %0d want 3 0 0", run_count, busy, run_errs);
        end
    endtask

    task automatic test_saturation();
        int n; logic [2:0] re[2]; logic [2:0] te[2];
        n = 0;
        stuck_en = 1'b1;
        @(negedge clk);
        pattern_sel = 2'b01; hold_cycles = 16'd0; continuous = 1'b1; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done_s === 1'b1) begin
                if (n < 2) begin re[n] = run_errs_s; te[n] = total_errs_s; end
                n++;
            end
            if (n == 1) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0; stuck_en = 1'b0; continuous = 1'b0;
        checks++;
        if (n !== 2) begin errors++; $display("FAIL sat_pulses: got %0d want 2", n); end
        else begin
            checks++;
            if (re[0] !== 3'd7 || te[0] !== 3'd7 || re[1] !== 3'd7 || te[1] !== 3'd7) begin
                errors++; $display("FAIL sat_vals: got %0d/%0d %0d/%0d want 7/7 7/7", re[0], te[0], re[1], te[1]);
            end
        end
        checks++;
        if (run_count_s !== 3'd2 || busy_s !== 1'b0) begin
            errors++; $display("FAIL sat_end: count %0d busy %b want 2 0", run_count_s, busy_s);
        end
    endtask

    task automatic test_start_ignored();
        int dk; logic [31:0] modes, dins;
        run_one(2'b01, 16'd4, -1, 3, dk, modes, dins);
        checks++;
        if (dk !== 20 || run_errs !== 16'd0 || run_count !== 16'd1) begin
            errors++; $display("FAIL restart: done %0d errs %0d count %0d want 20 0 1", dk, run_errs, run_count);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL restart_idle: busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int dk;
        dk = -1;
        stuck_en = 1'b1;
        pulse_start(2'b01, 16'd0, 1'b1);
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 && dk < 0) dk = k;
            if (k == 20) break;
            @(negedge clk);
        end
        checks++;
        if (dk !== 17 || run_errs !== 16'd8 || busy !== 1'b1 || sr_mode !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: done %0d errs %0d busy %b mode %b want 17 8 1 1", dk, run_errs, busy, sr_mode);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({sr_mode, sr_din, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_ctrl: got %b want 0000", {sr_mode, sr_din, busy, done});
        end
        checks++;
        if ({run_errs, total_errs, run_count} !== 48'd0 || first_err_idx !== 3'd7) begin
            errors++; $display("FAIL rstmid_cnt: got %0d/%0d/%0d fei %0d want 0/0/0 7",
                               run_errs, total_errs, run_count, first_err_idx);
        end
        @(negedge clk);
        rst = 1'b0; stuck_en = 1'b0; continuous = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sr_mode !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: busy %b mode %b want 0 0", busy, sr_mode);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_upset();
        test_stuck();
        test_continuous();
        test_saturation();
        test_start_ignored();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seu_shift_chain_ctrl.md
Name: seu_shift_chain_ctrl

Overview:
Sequencer for the SEU test shift chain: a LENGTH-bit shift register with a serial data input, a shift/hold mode input and a serial data output.
- Run cycle: fill the chain with a known pattern, hold it for a programmable exposure window, then shift it out while refilling it.
- Every bit shifted out is compared against the expected pattern; per-run and cumulative upset counts are reported.
- Sits between the slow-control/config block and the chain; one controller per chain.

Parameters:
LENGTH, 50, chain length in bits (≥2); must match the driven chain
HOLD_W, 16, width of the hold_cycles input
CNT_W, 16, width of the error and run counters
IDX_W, $clog2(LENGTH), width of the bit index

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle run request
continuous  in  1  sampled at start; 1 = loop runs until stop
stop  in  1  level; ends a continuous sequence after the current readout
pattern_sel  in  2  00 all-0, 01 all-1, 10 checkerboard (bit k = k[0]), 11 double-checker (bit k = k[1])
hold_cycles  in  HOLD_W  exposure length in cycles, sampled at start
sr_mode  out  1  to chain mode input; 1 = shift, 0 = hold
sr_din  out  1  to chain serial data input
sr_dout  in  1  from chain serial data output
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse per completed readout
run_errs  out  CNT_W  mismatches in the last completed readout
total_errs  out  CNT_W  mismatches since last start, saturating
run_count  out  CNT_W  completed readouts since last start, wrapping
first_err_idx  out  IDX_W  see Optional Feature

Behaviour:
- Reset (asynchronous, active-high): state IDLE; sr_mode=0, sr_din=0, busy=0, done=0; all counters 0; first_err_idx all-ones.
- All outputs are registered.
- States and transitions:
  - IDLE → FILL on start. On that edge: latch continuous, pattern_sel and hold_cycles; clear run_errs, total_errs, run_count; bit index idx=0.
  - FILL: exactly LENGTH cycles, sr_mode=1, sr_din=pattern(idx), idx increments each cycle. → HOLD after idx=LENGTH-1.
  - HOLD: sr_mode=0, sr_din=0 for max(hold_cycles,1) cycles. → READOUT with idx=0.
  - READOUT: exactly LENGTH cycles, sr_mode=1, sr_din=pattern(idx). On each edge, sr_dout is compared with pattern(idx); a mismatch increments the run error accumulator (saturating). Chain is FIFO order, so sr_dout in readout cycle k is the bit written in fill cycle k.
  - Leaving READOUT (after idx=LENGTH-1):
    - done=1 for one cycle.
    - run_errs ← accumulator, including the final bit's comparison.
    - total_errs += accumulator, saturating at all-ones.
    - run_count += 1, wrapping.
    - Next state: HOLD if latched continuous=1 and stop=0 (chain already refilled by READOUT); otherwise IDLE.
- Latency, no continuous: done is asserted 2·LENGTH + max(hold_cycles,1) cycles after the edge that samples start.
- start while busy: ignored; latched config unchanged.
- stop: has effect only in the final READOUT cycle of a continuous sequence; no mid-run abort.
- Reset mid-operation: immediate return to reset values. Chain contents are don't-care.
- sr_dout is ignored outside READOUT.

Optional Feature:
- Macro SEU_SHIFT_CHAIN_CTRL_ERRLOG_EN.
- Defined:
  - A register captures idx of the first mismatch in each readout.
  - It is reset to all-ones at READOUT entry.
  - It is copied to first_err_idx when done is asserted; all-ones means no error.
- Undefined:
  - No capture logic.
  - first_err_idx is tied to all-ones.

Test Plan:
- LENGTH=8, hold_cycles=4, pattern 01, ideal chain model, start pulse → sr_mode high 8 cycles, low 4, high 8; done at cycle 20 after start; run_errs=0, run_count=1, busy low the cycle after done.
- Same setup, bench flips chain bit 3 during HOLD → run_errs=1, total_errs=1; with ERRLOG_EN, first_err_idx=4 (bit position 3 exits at readout index 4).
- pattern 10, sr_dout forced stuck-at-0 → run_errs=4 (LENGTH/2); with pattern 01 → run_errs=8.
- continuous=1, hold_cycles=0, ideal chain, stop asserted during the 3rd READOUT → three done pulses 9 cycles apart (HOLD 1 + READOUT 8), run_count=3, then IDLE.
- Saturation: CNT_W=3, stuck-at-0 with pattern 01, continuous → run_errs=7, total_errs holds at 7.
- start pulse during FILL ignored; rst asserted mid-READOUT → same-cycle sr_mode=0, busy=0, counters 0, first_err_idx all-ones.
